mult_div_unit: RTL and testbench
================================

# mult_div_unit

EX-stage multiply/divide unit with architectural HI/LO registers. It consumes the registered start pulse, operand data and mult/div/mthi/mtlo decode produced by the decode stage's ID/EX pipeline register. It runs mult/multu in 5 cycles and div/divu in 10 cycles. It exposes `Busy` so the hazard unit can stall any mult-type instruction in decode while an operation is pending or starting.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  request for mult/multu/div/divu in EX this cycle.
- `MDOp`  in  2  operation select, sampled with `Start`: 00 mult, 01 multu, 10 div, 11 divu.
- `WriteHi`  in  1  mthi in EX this cycle.
- `WriteLo`  in  1  mtlo in EX this cycle.
- `Src0`  in  32  forwarded rs value (dividend / multiplicand / mthi-mtlo data).
- `Src1`  in  32  forwarded rt value (divisor / multiplier).
- `Suppress`  in  1  exception or eret flush of the EX instruction; blocks `Start`, `WriteHi` and `WriteLo` this cycle.
- `Busy`  out  1  operation pending; registered.
- `Done`  out  1  one-cycle pulse in the first cycle HI/LO show a new mult/div result; registered.
- `HI`  out  32  HI register; registered.
- `LO`  out  32  LO register; registered.

## Operation
- States: IDLE and RUN. A counter tracks cycles remaining in RUN.
- **Accepting Start:** in IDLE, a rising edge with `Start=1` and `Suppress=0`:
  - computes the result from `Src0`/`Src1`/`MDOp` and stores it in pending registers;
  - loads the counter with `MULT_CYCLES` or `DIV_CYCLES`;
  - enters RUN.
- **Arithmetic rules:**
  - mult: signed 32×32 to 64 bits; HI = [63:32], LO = [31:0].
  - multu: the same with unsigned operands.
  - div: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - divu: the unsigned equivalent.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0: the full `DIV_CYCLES` still elapse, and HI/LO keep their prior values. No exception is raised.
- **RUN:** the counter decrements each edge. On the edge where the counter reaches 1:
  - HI/LO load the pending result;
  - state returns to IDLE and `Busy` falls;
  - `Done` is asserted for the following cycle.
- **mthi/mtlo:** in IDLE with `Suppress=0`, `WriteHi` writes HI←`Src0` and `WriteLo` writes LO←`Src0` at the edge. If both are high, both registers are written.
- **Ignored requests:** `Start`, `WriteHi` and `WriteLo` are ignored while in RUN. The hazard unit guarantees they never occur there; the bench flags them as errors.
- **Priority:** `Start` together with `WriteHi` or `WriteLo` in the same cycle gives `Start` priority, and the write is dropped.
- **Suppress:** affects only the current-cycle request. An operation already in RUN is never cancelled by `Suppress`; it completes and commits.
- **Reset:** `reset` overrides everything, including mid-RUN. The pending result is discarded and the counter is cleared.

## Timing
- **Reset values:** `Busy`=0, `Done`=0, `HI`=0, `LO`=0, state IDLE.
- **Latency:** `Start` accepted at edge E0:
  - `Busy`=1 during cycles E0..E(N-1), where N = `MULT_CYCLES` or `DIV_CYCLES`;
  - HI/LO update at edge EN;
  - `Busy`=0 and `Done`=1 during cycle EN..E(N+1).
- **mthi/mtlo:** visible on `HI`/`LO` in the cycle after the edge. There is no busy period.
- **Back-to-back:** a new `Start` is accepted at EN, since the state is IDLE from that cycle on. The hazard unit stalls decode while `Start|Busy`, so mfhi/mflo reach EX no earlier than EN.
- **Combinational paths:** none from inputs to outputs.

## Test plan
- **Signed mult:** mult, `Src0`=0xFFFFFFFE, `Src1`=3 -> `Busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, `Done` pulses once.
- **Unsigned mult then signed div:** multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA. Then div, 0xFFFFFFF9 (-7) / 2 -> `Busy` 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Divide by zero and overflow case:** mthi 0x11111111 and mtlo 0x22222222, then divu by 0 -> after 10 cycles HI/LO still 0x11111111/0x22222222. Signed 0x80000000 / -1 -> LO=0x80000000, HI=0.
- **Suppress:** `Start` with `Suppress`=1 -> `Busy` stays 0, HI/LO unchanged. Then assert `Suppress` during RUN of a mult 7×6 -> LO=42 still commits at E5.
- **Reset mid-operation:** `reset` at cycle 3 of a div -> next cycle `Busy`=0, HI=LO=0, no `Done` pulse. A following mult 2×3 gives LO=6.
- **Back-to-back and priority:** `Start` at E5 of a previous mult is accepted, and `Busy` re-asserts immediately. `Start` with `WriteLo` in the same cycle -> the mtlo data never appears on LO.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: EX-stage multiply/divide unit with HI/LO registers, fixed-latency busy window.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic        WriteHi,
  input  logic        WriteLo,
  input  logic [31:0] Src0,
  input  logic [31:0] Src1,
  input  logic        Suppress,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam logic IDLE = 1'b0;
  localparam logic RUN = 1'b1;
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  logic state;
  logic [CW-1:0] cnt;
  logic [31:0] pend_hi, pend_lo;
  logic pend_keep;
  logic sgn, is_div, div_zero, q_neg, r_neg;
  logic [63:0] prod;
  logic [31:0] abs_a, abs_b, q, r, res_hi, res_lo;
  assign Busy = state;
  // Signed divide works on magnitudes; 0x80000000 negates to itself, which as unsigned is exactly 2^31.
  always_comb begin
    sgn = ~MDOp[0];
    is_div = MDOp[1];
    div_zero = Src1 == 32'd0;
    prod = {{32{sgn & Src0[31]}}, Src0} * {{32{sgn & Src1[31]}}, Src1};
    abs_a = sgn & Src0[31] ? -Src0 : Src0;
    abs_b = div_zero ? 32'd1 : sgn & Src1[31] ? -Src1 : Src1;
    q = abs_a / abs_b;
    r = abs_a % abs_b;
    q_neg = sgn & (Src0[31] ^ Src1[31]);
    r_neg = sgn & Src0[31];
    res_lo = is_div ? (q_neg ? -q : q) : prod[31:0];
    res_hi = is_div ? (r_neg ? -r : r) : prod[63:32];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_keep <= 1'b0;
      Done <= 1'b0;
      HI <= '0;
      LO <= '0;
    end else begin
      Done <= state == RUN && cnt == CW'(1);
      if (state == IDLE) begin
        if (Start && !Suppress) begin
          state <= RUN;
          cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          pend_hi <= res_hi;
          pend_lo <= res_lo;
          pend_keep <= is_div && div_zero;
        end else if (!Suppress) begin
          if (WriteHi) HI <= Src0;
          if (WriteLo) LO <= Src0;
        end
      end else begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state <= IDLE;
          if (!pend_keep) begin
            HI <= pend_hi;
            LO <= pend_lo;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against an arithmetic HI/LO model.
module tb_mult_div_unit;
  logic clk = 0, reset = 1, Start = 0, WriteHi = 0, WriteLo = 0, Suppress = 0;
  logic [1:0] MDOp = 0;
  logic [31:0] Src0 = 0, Src1 = 0;
  logic Busy, Done;
  logic [31:0] HI, LO;
  int tests = 0, fails = 0;
  logic [31:0] exp_hi = 0, exp_lo = 0;
  mult_div_unit dut (.clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .WriteHi(WriteHi),
    .WriteLo(WriteLo), .Src0(Src0), .Src1(Src1), .Suppress(Suppress), .Busy(Busy), .Done(Done),
    .HI(HI), .LO(LO));
  always #5 clk = ~clk;
  // Architectural model: updates exp_hi/exp_lo as the MIPS ISA defines the operation.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sb;
    sa = a;
    sb = b;
    if (op == 2'd0) begin
      p = longint'($signed(a)) * longint'($signed(b));
      {exp_hi, exp_lo} = p;
    end else if (op == 2'd1) begin
      p = longint'({32'd0, a}) * longint'({32'd0, b});
      {exp_hi, exp_lo} = p;
    end else if (b != 0) begin
      if (op == 2'd3) begin
        exp_lo = a / b;
        exp_hi = a % b;
      end else if (sa == int'(32'h80000000) && sb == -1) begin
        exp_lo = 32'h80000000;
        exp_hi = 0;
      end else begin
        exp_lo = sa / sb;
        exp_hi = sa % sb;
      end
    end
  endtask
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic sup, output int nb, output int nd);
    @(negedge clk);
    Start = 1; MDOp = op; Src0 = a; Src1 = b;
    @(negedge clk);
    Start = 0; Suppress = sup;
    nb = 0; nd = 0;
    while (Busy && nb < 40) begin
      nb++;
      nd += int'(Done);
      @(negedge clk);
    end
    Suppress = 0;
    nd += int'(Done);
    @(negedge clk);
    nd += int'(Done);
  endtask
  task automatic wr(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    WriteHi = h; WriteLo = l; Src0 = d;
    @(negedge clk);
    WriteHi = 0; WriteLo = 0;
    if (h) exp_hi = d;
    if (l) exp_lo = d;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    reset = 0;
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", Busy); end
    tests++; if (Done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", Done); end
    tests++; if (HI !== 32'd0) begin fails++; $display("FAIL reset_hi: got %h want 0", HI); end
    tests++; if (LO !== 32'd0) begin fails++; $display("FAIL reset_lo: got %h want 0", LO); end
  endtask
  task automatic test_directed;
    int nb, nd;
    logic [1:0] ops [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] as [5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd100, 32'h80000000};
    logic [31:0] bs [5] = '{32'd3, 32'd3, 32'd2, 32'd7, 32'hFFFFFFFF};
    logic [31:0] want_hi [5] = '{32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'd2, 32'd0};
    logic [31:0] want_lo [5] = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFD, 32'd14, 32'h80000000};
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], as[i], bs[i], 1'b0, nb, nd);
      model(ops[i], as[i], bs[i]);
      tests++; if (nb != (ops[i][1] ? 10 : 5)) begin fails++; $display("FAIL dir%0d_busy: got %0d cycles want %0d", i, nb, ops[i][1] ? 10 : 5); end
      tests++; if (nd != 1) begin fails++; $display("FAIL dir%0d_done: got %0d pulses want 1", i, nd); end
      tests++; if (HI !== want_hi[i]) begin fails++; $display("FAIL dir%0d_hi: got %h want %h", i, HI, want_hi[i]); end
      tests++; if (LO !== want_lo[i]) begin fails++; $display("FAIL dir%0d_lo: got %h want %h", i, LO, want_lo[i]); end
    end
  endtask
  task automatic test_div_zero;
    int nb, nd;
    wr(1'b1, 1'b0, 32'h11111111);
    tests++; if (HI !== 32'h11111111) begin fails++; $display("FAIL mthi: got %h want 11111111", HI); end
    wr(1'b0, 1'b1, 32'h22222222);
    tests++; if (LO !== 32'h22222222) begin fails++; $display("FAIL mtlo: got %h want 22222222", LO); end
    do_op(2'd3, 32'd1234, 32'd0, 1'b0, nb, nd);
    tests++; if (nb != 10) begin fails++; $display("FAIL divz_busy: got %0d want 10", nb); end
    tests++; if (HI !== 32'h11111111) begin fails++; $display("FAIL divz_hi: got %h want 11111111", HI); end
    tests++; if (LO !== 32'h22222222) begin fails++; $display("FAIL divz_lo: got %h want 22222222", LO); end
    wr(1'b1, 1'b1, 32'hA5A5A5A5);
    tests++; if ({HI, LO} !== {2{32'hA5A5A5A5}}) begin fails++; $display("FAIL mthilo: got %h %h want a5a5a5a5 x2", HI, LO); end
  endtask
  task automatic test_suppress;
    int nb, nd;
    @(negedge clk);
    Start = 1; Suppress = 1; MDOp = 2'd0; Src0 = 32'd9; Src1 = 32'd9;
    @(negedge clk);
    Start = 0; WriteLo = 1; Src0 = 32'hDEADBEEF;
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL sup_busy: got %b want 0", Busy); end
    @(negedge clk);
    WriteLo = 0; Suppress = 0;
    tests++; if ({HI, LO} !== {exp_hi, exp_lo}) begin fails++; $display("FAIL sup_hold: got %h %h want %h %h", HI, LO, exp_hi, exp_lo); end
    do_op(2'd0, 32'd7, 32'd6, 1'b1, nb, nd);
    tests++; if (nb != 5) begin fails++; $display("FAIL sup_run_busy: got %0d want 5", nb); end
    tests++; if (LO !== 32'd42 || HI !== 32'd0) begin fails++; $display("FAIL sup_run_res: got %h %h want 0 2a", HI, LO); end
    exp_hi = 0; exp_lo = 42;
  endtask
  task automatic test_reset_mid;
    int nb, nd;
    @(negedge clk);
    Start = 1; MDOp = 2'd2; Src0 = 32'd100; Src1 = 32'd3;
    @(negedge clk);
    Start = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    exp_hi = 0; exp_lo = 0;
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b want 0", Busy); end
    tests++; if ({HI, LO} !== 64'd0) begin fails++; $display("FAIL rmid_hilo: got %h %h want 0 0", HI, LO); end
    nd = 0;
    repeat (12) begin
      nd += int'(Done);
      @(negedge clk);
    end
    tests++; if (nd != 0 || LO !== 32'd0) begin fails++; $display("FAIL rmid_nodone: got %0d pulses lo %h want 0", nd, LO); end
    do_op(2'd0, 32'd2, 32'd3, 1'b0, nb, nd);
    tests++; if (LO !== 32'd6) begin fails++; $display("FAIL rmid_after: got %h want 6", LO); end
    exp_lo = 6;
  endtask
  task automatic test_back_to_back;
    int nb;
    @(negedge clk);
    Start = 1; MDOp = 2'd1; Src0 = 32'd11; Src1 = 32'd13;
    @(negedge clk);
    Start = 0;
    nb = 0;
    while (Busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    tests++; if (Done !== 1'b1 || LO !== 32'd143) begin fails++; $display("FAIL b2b_first: done %b lo %h want 1 8f", Done, LO); end
    Start = 1; WriteLo = 1; MDOp = 2'd0; Src0 = 32'd3; Src1 = 32'd5;
    @(negedge clk);
    Start = 0; WriteLo = 0;
    tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL b2b_busy: got %b want 1", Busy); end
    tests++; if (LO !== 32'd143) begin fails++; $display("FAIL b2b_prio: got %h want 8f", LO); end
    nb = 0;
    while (Busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    tests++; if (nb != 5) begin fails++; $display("FAIL b2b_len: got %0d want 5", nb); end
    tests++; if ({HI, LO} !== {32'd0, 32'd15}) begin fails++; $display("FAIL b2b_res: got %h %h want 0 f", HI, LO); end
    exp_hi = 0; exp_lo = 15;
  endtask
  task automatic test_random;
    int nb, nd;
    logic [1:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) wr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom_range(0, 5) == 0 ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      do_op(op, a, b, 1'($urandom_range(0, 1)), nb, nd);
      model(op, a, b);
      tests++; if (nb != (op[1] ? 10 : 5)) begin fails++; $display("FAIL rnd%0d_busy: got %0d want %0d", i, nb, op[1] ? 10 : 5); end
      tests++; if ({HI, LO} !== {exp_hi, exp_lo}) begin fails++; $display("FAIL rnd%0d_res op%0d %h %h: got %h %h want %h %h", i, op, a, b, HI, LO, exp_hi, exp_lo); end
    end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_div_zero;
    test_suppress;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
